// File: rtl/forwarder_pkg.sv
// Shared types and helpers for the AXI-Stream packet forwarder.
package forwarder_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_STREAM = 2'd1;
    localparam logic [1:0] ST_DRAIN  = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    localparam int BEAT_BYTES = 8;
    localparam int KEEP_WIDTH = 8;
    localparam int DATA_WIDTH = 64;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] data;
        logic [KEEP_WIDTH-1:0] keep;
        logic                  last;
    } beat_t;

    // Byte-enable mask for the final beat given len % 8.
    function automatic logic [KEEP_WIDTH-1:0] lastkeep(input logic [2:0] rem);
        logic [KEEP_WIDTH-1:0] k;
        k = '1;
        if (rem != 3'd0) begin
            k = (8'd1 << rem) - 8'd1;
        end
        return k;
    endfunction

endpackage

// File: rtl/fwd_skid_fifo.sv
// Two-entry beat FIFO whose head entry is a register driving the AXI outputs.
module fwd_skid_fifo
    import forwarder_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  beat_t      din,
    input  logic       pop,
    output logic [1:0] count,
    output beat_t      head
);

    beat_t      head_q;
    beat_t      tail_q;
    logic [1:0] cnt_q;
    logic       pop_ok;

    assign pop_ok = pop && (cnt_q != 2'd0);

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q <= '0;
            tail_q <= '0;
            cnt_q  <= 2'd0;
        end else begin
            unique case ({push, pop_ok})
                2'b10: begin
                    if (cnt_q == 2'd0) begin
                        head_q <= din;
                    end else begin
                        tail_q <= din;
                    end
                    cnt_q <= cnt_q + 2'd1;
                end
                2'b01: begin
                    head_q <= tail_q;
                    cnt_q  <= cnt_q - 2'd1;
                end
                2'b11: begin
                    // Count is unchanged; the new beat lands behind any survivor.
                    if (cnt_q == 2'd2) begin
                        head_q <= tail_q;
                        tail_q <= din;
                    end else begin
                        head_q <= din;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign count = cnt_q;
    assign head  = head_q;

endmodule

// File: rtl/axis_forwarder.sv
// Reads a filled packet buffer as 64-bit words and emits it as one AXI-Stream packet.
module axis_forwarder
    import forwarder_pkg::*;
#(
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ready_for_forwarder,
    input  logic [31:0]           len_to_forwarder,
    output logic [ADDR_WIDTH-1:0] forwarder_rd_addr,
    output logic                  forwarder_rd_en,
    input  logic [63:0]           forwarder_rd_data,
    output logic                  forwarder_done,
    output logic [63:0]           m_axis_tdata,
    output logic [7:0]            m_axis_tkeep,
    output logic                  m_axis_tlast,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready
);

    localparam int MAX_BEATS = 2 ** (ADDR_WIDTH - 1);
    localparam int MAX_BYTES = MAX_BEATS * BEAT_BYTES;
    localparam int CW        = ADDR_WIDTH + 3;
    localparam logic [31:0]           MAXB32 = 32'(MAX_BYTES);
    localparam logic [CW-1:0]         MAXB_N = CW'(MAX_BYTES);
    localparam logic [ADDR_WIDTH-1:0] ONE    = ADDR_WIDTH'(1);

    logic [1:0]            state;
    logic [1:0]            state_nxt;
    logic [ADDR_WIDTH-1:0] rd_cnt;
    logic [ADDR_WIDTH-1:0] rd_idx;
    logic [ADDR_WIDTH-1:0] nbeats;
    logic [ADDR_WIDTH-1:0] last_idx;
    logic [KEEP_WIDTH-1:0] lkeep;
    logic                  in_flight;

    logic                  over;
    logic [CW-1:0]         clamped;
    logic [ADDR_WIDTH-1:0] nbeats_in;
    logic                  start;

    logic [1:0]            fifo_cnt;
    beat_t                 head;
    beat_t                 push_beat;
    logic                  pop;
    logic [2:0]            occ;
    logic                  credit;
    logic                  rd_last;
    logic                  drained;

    // Beat count and last-beat mask for the incoming length.
    assign over      = len_to_forwarder > MAXB32;
    assign clamped   = over ? MAXB_N : len_to_forwarder[CW-1:0];
    assign nbeats_in = clamped[CW-1:3] + ADDR_WIDTH'(|clamped[2:0]);
    assign start     = (state == ST_IDLE) && ready_for_forwarder
                    && (len_to_forwarder != 32'd0);

    assign last_idx = nbeats - ONE;
    assign rd_last  = (rd_cnt == last_idx);
    assign pop      = m_axis_tvalid && m_axis_tready;

    // Slots freed by this cycle's handshake count as credit, keeping 1 beat/cycle.
    assign occ     = 3'(fifo_cnt) + 3'(in_flight) - 3'(pop);
    assign credit  = occ < 3'd2;
    assign drained = !in_flight
                  && ((fifo_cnt == 2'd0) || ((fifo_cnt == 2'd1) && pop));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE: begin
                if (ready_for_forwarder) begin
                    if (len_to_forwarder == 32'd0) begin
                        state_nxt = ST_DONE;
                    end else begin
                        state_nxt = ST_STREAM;
                    end
                end
            end
            ST_STREAM: begin
                if (credit && rd_last) begin
                    state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (drained) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        forwarder_rd_en   = 1'b0;
        forwarder_rd_addr = '0;
        forwarder_done    = 1'b0;
        unique case (state)
            ST_STREAM: begin
                forwarder_rd_en   = credit;
                forwarder_rd_addr = rd_cnt;
            end
            ST_DONE: begin
                forwarder_done = 1'b1;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_cnt    <= '0;
            rd_idx    <= '0;
            nbeats    <= '0;
            lkeep     <= '0;
            in_flight <= 1'b0;
        end else begin
            in_flight <= forwarder_rd_en;
            if (start) begin
                nbeats <= nbeats_in;
                lkeep  <= over ? 8'hFF : lastkeep(len_to_forwarder[2:0]);
                rd_cnt <= '0;
            end else if (forwarder_rd_en) begin
                rd_cnt <= rd_cnt + ONE;
            end
            if (forwarder_rd_en) begin
                rd_idx <= rd_cnt;
            end
        end
    end

    always_comb begin
        push_beat.data = forwarder_rd_data;
        push_beat.last = (rd_idx == last_idx);
        push_beat.keep = push_beat.last ? lkeep : 8'hFF;
    end

    fwd_skid_fifo u_skid (
        .clk   (clk),
        .rst   (rst),
        .push  (in_flight),
        .din   (push_beat),
        .pop   (pop),
        .count (fifo_cnt),
        .head  (head)
    );

    assign m_axis_tvalid = (fifo_cnt != 2'd0);
    assign m_axis_tdata  = head.data;
    assign m_axis_tkeep  = head.keep;
    assign m_axis_tlast  = head.last;

endmodule

// File: doc/axis_forwarder.md
# axis_forwarder

Downstream consumer of the three-buffer packet memory: when the memory hands it a filled buffer (`ready_for_forwarder`), it reads the packet out as 64-bit words and emits it as one AXI4-Stream packet, honouring `tready` back-pressure. After the last beat is accepted it returns the buffer with a one-cycle `forwarder_done` pulse. It sits between `packetmem`'s forwarder port and the outgoing AXI-Stream interface.

## Interface
- `ADDR_WIDTH`, 10: matches packetmem; buffer holds 2^(ADDR_WIDTH-1) 64-bit words.
- `clk` in 1: single clock.
- `rst` in 1: reset, synchronous, active-high.
- `ready_for_forwarder` in 1: packetmem has a buffer assigned to the forwarder.
- `len_to_forwarder` in 32: packet length in bytes of that buffer.
- `forwarder_rd_addr` out ADDR_WIDTH: 64-bit word index; MSB always 0.
- `forwarder_rd_en` out 1: read strobe.
- `forwarder_rd_data` in 64: read data, valid the cycle after `forwarder_rd_en`; lower-addressed 32-bit word in [31:0].
- `forwarder_done` out 1: one-cycle pulse that releases the buffer.
- `m_axis_tdata` out 64, `m_axis_tkeep` out 8, `m_axis_tlast` out 1, `m_axis_tvalid` out 1, `m_axis_tready` in 1: AXI-Stream master; byte 0 of the packet is `tdata[7:0]`.

## Operation
- States: IDLE, STREAM, DRAIN, DONE.
- IDLE:
  - On `ready_for_forwarder` with len != 0: latch `nbeats = ceil(min(len, MAXB)/8)` and `lastkeep`, where MAXB = 8·2^(ADDR_WIDTH-1). Clear the read counter; go to STREAM.
  - On `ready_for_forwarder` with len == 0: go straight to DONE, so the empty buffer is dropped and nothing is emitted.
- STREAM:
  - `forwarder_rd_en` = 1 when credit is available, meaning (entries held in the skid buffer + reads in flight) < 2. `forwarder_rd_addr` = read counter.
  - Each strobe increments the counter. The strobe for index nbeats-1 moves the block to DRAIN.
- DRAIN: no reads. Wait until the skid buffer is empty and no read is in flight, then go to DONE.
- DONE: `forwarder_done` = 1 for exactly one cycle, then go to IDLE.
- Read data is pushed into the 2-entry skid buffer the cycle after its strobe, tagged with its beat index. The head of the buffer drives the AXI outputs.
- The beat with index nbeats-1 has `tlast` = 1 and `tkeep` = lastkeep. lastkeep = 8'hFF when len%8 == 0; otherwise it is (1<<(len%8))-1. Every other beat has `tkeep` = 8'hFF.
- Clamping: if len > MAXB, exactly MAXB bytes are sent and `tkeep` on the last beat is 8'hFF.
- Width rules: the beat count is held in ADDR_WIDTH bits; len%8 is taken from len[2:0] of the unclamped length.

## Timing
- Reset values: `m_axis_tvalid`, `m_axis_tlast`, `forwarder_rd_en`, `forwarder_done` = 0; `forwarder_rd_addr` = 0; `m_axis_tkeep` = 0; `m_axis_tdata` = 0; state = IDLE; skid buffer empty.
- `forwarder_rd_en` and `forwarder_rd_addr` are combinational from state, counter and credit. All AXI outputs are registered (driven by the skid buffer head).
- Latency: `ready_for_forwarder` sampled in IDLE at cycle N → first `rd_en` at N+1 → data captured at end of N+2 → `tvalid` = 1 at N+3.
- Throughput: 1 beat/cycle while `tready` is held high.
- While `tvalid` = 1 and `tready` = 0, `tdata`/`tkeep`/`tlast` are held stable. No beat is lost or duplicated: the credit rule guarantees that an in-flight read always finds a free slot.
- Last-beat handshake at cycle M → `forwarder_done` at M+1 (DRAIN→DONE) → IDLE at M+2. packetmem updates its selection on the edge after `done`, so `ready_for_forwarder` in IDLE is already valid.
- `ready_for_forwarder` is ignored outside IDLE; its deassertion mid-packet has no effect.
- `rst` mid-packet: state returns to IDLE and `tvalid` drops at the next edge. In-flight read data is discarded and no `done` pulse is issued; packetmem is reset by the same reset tree.

## Structure
- Shared package (`forwarder_pkg`): state encoding localparams, BEAT_BYTES = 8, KEEP_WIDTH = 8, and the lastkeep function.
- One sub-module: `fwd_skid_fifo`, a 2-entry FIFO of {tdata, tkeep, tlast} with push, pop (= `tvalid`&`tready`), count and registered head outputs.
- Top level: FSM, beat counter, credit/in-flight tracking, lastkeep/tlast tagging.

## Test plan
- len = 64, `tready` = 1: 8 beats on consecutive cycles starting N+3; the last has `tkeep` = FF and `tlast` = 1; `done` is one pulse one cycle after the last handshake.
- len = 13: 2 beats, keep FF then 1F; `rd_addr` sequence 0,1; data word order is checked against memory contents.
- len = 0: no `tvalid` ever; `done` pulses at N+1.
- len = 40 with `tready` toggling 1,0,0,1 randomly: all 5 beats are emitted in order with no duplication; data is stable while stalled; at most 2 reads are outstanding beyond accepted beats.
- len = 9000 with ADDR_WIDTH = 10 (MAXB = 4096): exactly 512 beats; the last has keep FF.
- Assert `rst` during beat 3 of 8: `tvalid` = 0 the next cycle, no `done`; a subsequent len = 8 packet is sent correctly as 1 beat with keep FF.
